// File: rtl/multdiv_pkg.sv
// Shared types and defaults for the multiply/divide sequencer.
//   state_t : sequencer FSM states
//   op_t    : operation encoding carried through the op slots
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_t;

    localparam int DEFAULT_DATA_W     = 32;
    localparam int DEFAULT_TAG_W      = 5;
    localparam int DEFAULT_MAX_CYCLES = 40;
    localparam int RUN_CNT_W          = 6;

endpackage

// File: rtl/multdiv_op_slot.sv
// One operation holding slot: valid flag, op, destination tag and operands.
// Ports:
//   clock, clear       : clock and asynchronous active-high reset
//   load               : capture load_* and set valid (wins over flush)
//   flush              : drop valid; the held fields are left as they are
//   load_op/tag/a/b    : data captured on load
//   valid/op/tag/a/b   : current slot contents
module multdiv_op_slot
    import multdiv_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int TAG_W  = DEFAULT_TAG_W
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              load,
    input  logic              flush,
    input  op_t               load_op,
    input  logic [TAG_W-1:0]  load_tag,
    input  logic [DATA_W-1:0] load_a,
    input  logic [DATA_W-1:0] load_b,
    output logic              valid,
    output op_t               op,
    output logic [TAG_W-1:0]  tag,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b
);

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            valid <= 1'b0;
            op    <= OP_MULT;
            tag   <= '0;
            a     <= '0;
            b     <= '0;
        end else if (load) begin
            valid <= 1'b1;
            op    <= load_op;
            tag   <= load_tag;
            a     <= load_a;
            b     <= load_b;
        end else if (flush) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/multdiv_sequencer.sv
// Sequences a shared multiplier and divider. Requests are latched into an
// active slot (or a pending slot while one op is in flight), the selected
// unit is cleared, enabled until its ready (or a watchdog expires), and the
// result, exception and tag are presented for one cycle with result_valid.
// Ports:
//   clock, clear                 : clock, asynchronous active-high reset
//   ctrl_MULT/ctrl_DIV           : one-cycle request pulses
//   data_operandA/B, op_tag      : request operands and destination tag
//   req_ready, busy, illegal_req : request handshake / status
//   unit_opA/B                   : operands of the active op to both units
//   mult_clr/en, mult_*          : multiplier control and response
//   div_clr/en, div_*            : divider control and response
//   result*, result_valid        : completion data and strobe
//   timeout                      : completion caused by the watchdog
module multdiv_sequencer
    import multdiv_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int TAG_W      = DEFAULT_TAG_W,
    parameter int MAX_CYCLES = DEFAULT_MAX_CYCLES
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              ctrl_MULT,
    input  logic              ctrl_DIV,
    input  logic [DATA_W-1:0] data_operandA,
    input  logic [DATA_W-1:0] data_operandB,
    input  logic [TAG_W-1:0]  op_tag,
    output logic              req_ready,
    output logic              busy,
    output logic              illegal_req,
    output logic [DATA_W-1:0] unit_opA,
    output logic [DATA_W-1:0] unit_opB,
    output logic              mult_clr,
    output logic              mult_en,
    input  logic [DATA_W-1:0] mult_result,
    input  logic              mult_exception,
    input  logic              mult_rdy,
    output logic              div_clr,
    output logic              div_en,
    input  logic [DATA_W-1:0] div_result,
    input  logic              div_exception,
    input  logic              div_rdy,
    output logic [DATA_W-1:0] result,
    output logic              result_exception,
    output logic [TAG_W-1:0]  result_tag,
    output logic              result_valid,
    output logic              timeout
);

    localparam logic [RUN_CNT_W-1:0] RUN_LAST = RUN_CNT_W'(MAX_CYCLES - 1);

    state_t                state_reg, state_next;
    logic [RUN_CNT_W-1:0]  run_cnt_reg;
    logic [DATA_W-1:0]     result_reg;
    logic                  exc_reg;
    logic [TAG_W-1:0]      tag_reg;
    logic                  timeout_reg;

    logic                  act_valid, pend_valid;
    op_t                   act_op, pend_op, op_req;
    logic [TAG_W-1:0]      act_tag, pend_tag;
    logic [DATA_W-1:0]     act_a, act_b, pend_a, pend_b;

    logic                  accept, active_empty, act_from_pend;
    logic                  act_load, act_flush, pend_load;
    logic                  sel_rdy, sel_exc;
    logic [DATA_W-1:0]     sel_result;
    logic                  cap_en, cap_exc, cap_to;
    logic [DATA_W-1:0]     cap_result;

    // Request handshake: a simultaneous MULT+DIV request is rejected outright.
    assign op_req      = ctrl_DIV ? OP_DIV : OP_MULT;
    assign req_ready   = !pend_valid;
    assign accept      = req_ready & (ctrl_MULT ^ ctrl_DIV);
    assign illegal_req = ctrl_MULT & ctrl_DIV & !clear;

    // The active slot frees up during DONE; pending is promoted first, and only
    // with pending empty can a new request go straight into the active slot.
    assign active_empty  = !act_valid | (state_reg == DONE & !pend_valid);
    assign act_from_pend = (state_reg == DONE) & pend_valid;
    assign act_load      = act_from_pend | (accept & active_empty);
    assign act_flush     = (state_reg == DONE) & !act_load;
    assign pend_load     = accept & !active_empty;

    multdiv_op_slot #(.DATA_W(DATA_W), .TAG_W(TAG_W)) u_active (
        .clock    (clock),
        .clear    (clear),
        .load     (act_load),
        .flush    (act_flush),
        .load_op  (act_from_pend ? pend_op  : op_req),
        .load_tag (act_from_pend ? pend_tag : op_tag),
        .load_a   (act_from_pend ? pend_a   : data_operandA),
        .load_b   (act_from_pend ? pend_b   : data_operandB),
        .valid    (act_valid),
        .op       (act_op),
        .tag      (act_tag),
        .a        (act_a),
        .b        (act_b)
    );

    multdiv_op_slot #(.DATA_W(DATA_W), .TAG_W(TAG_W)) u_pending (
        .clock    (clock),
        .clear    (clear),
        .load     (pend_load),
        .flush    (act_from_pend),
        .load_op  (op_req),
        .load_tag (op_tag),
        .load_a   (data_operandA),
        .load_b   (data_operandB),
        .valid    (pend_valid),
        .op       (pend_op),
        .tag      (pend_tag),
        .a        (pend_a),
        .b        (pend_b)
    );

    assign sel_rdy    = (act_op == OP_DIV) ? div_rdy       : mult_rdy;
    assign sel_exc    = (act_op == OP_DIV) ? div_exception : mult_exception;
    assign sel_result = (act_op == OP_DIV) ? div_result    : mult_result;

    always_comb begin
        state_next = state_reg;
        cap_en     = 1'b0;
        cap_result = '0;
        cap_exc    = 1'b0;
        cap_to     = 1'b0;
        case (state_reg)
            IDLE: if (act_load) state_next = CLR;
            CLR: begin
                // Divide by zero is resolved here without running the divider.
                if (act_op == OP_DIV && act_b == '0) begin
                    state_next = DONE;
                    cap_en     = 1'b1;
                    cap_exc    = 1'b1;
                end else begin
                    state_next = RUN;
                end
            end
            RUN: begin
                // Ready takes priority over a watchdog expiring in the same cycle.
                if (sel_rdy) begin
                    state_next = DONE;
                    cap_en     = 1'b1;
                    cap_result = sel_result;
                    cap_exc    = sel_exc;
                end else if (run_cnt_reg == RUN_LAST) begin
                    state_next = DONE;
                    cap_en     = 1'b1;
                    cap_exc    = 1'b1;
                    cap_to     = 1'b1;
                end
            end
            DONE:    state_next = act_load ? CLR : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_reg   <= IDLE;
            run_cnt_reg <= '0;
            result_reg  <= '0;
            exc_reg     <= 1'b0;
            tag_reg     <= '0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == CLR)
                run_cnt_reg <= '0;
            else if (state_reg == RUN)
                run_cnt_reg <= run_cnt_reg + 1'b1;
            if (cap_en) begin
                result_reg  <= cap_result;
                exc_reg     <= cap_exc;
                tag_reg     <= act_tag;
                timeout_reg <= cap_to;
            end
        end
    end

    assign busy             = (state_reg != IDLE);
    assign result_valid     = (state_reg == DONE);
    assign timeout          = (state_reg == DONE) & timeout_reg;
    assign result           = result_reg;
    assign result_exception = exc_reg;
    assign result_tag       = tag_reg;
    assign unit_opA         = act_a;
    assign unit_opB         = act_b;

    // The idle unit sees clear only; the selected one is cleared in CLR and
    // enabled through RUN.
    assign mult_clr = clear | (state_reg == CLR & act_op == OP_MULT);
    assign mult_en  = (state_reg == RUN) & (act_op == OP_MULT);
    assign div_clr  = clear | (state_reg == CLR & act_op == OP_DIV);
    assign div_en   = (state_reg == RUN) & (act_op == OP_DIV);

endmodule

// File: tb/tb_multdiv_sequencer.sv
module tb_multdiv_sequencer;
    import multdiv_pkg::*;

    localparam int DATA_W     = 32;
    localparam int TAG_W      = 5;
    localparam int MAX_CYCLES = 40;

    logic              clock = 1'b0;
    logic              clear;
    logic              ctrl_MULT, ctrl_DIV;
    logic [DATA_W-1:0] data_operandA, data_operandB;
    logic [TAG_W-1:0]  op_tag;
    logic              req_ready, busy, illegal_req;
    logic [DATA_W-1:0] unit_opA, unit_opB;
    logic              mult_clr, mult_en, mult_exception, mult_rdy;
    logic              div_clr, div_en, div_exception, div_rdy;
    logic [DATA_W-1:0] mult_result, div_result;
    logic [DATA_W-1:0] result;
    logic              result_exception, result_valid, timeout;
    logic [TAG_W-1:0]  result_tag;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    multdiv_sequencer #(.DATA_W(DATA_W), .TAG_W(TAG_W), .MAX_CYCLES(MAX_CYCLES)) dut (
        .clock(clock), .clear(clear),
        .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
        .data_operandA(data_operandA), .data_operandB(data_operandB), .op_tag(op_tag),
        .req_ready(req_ready), .busy(busy), .illegal_req(illegal_req),
        .unit_opA(unit_opA), .unit_opB(unit_opB),
        .mult_clr(mult_clr), .mult_en(mult_en), .mult_result(mult_result),
        .mult_exception(mult_exception), .mult_rdy(mult_rdy),
        .div_clr(div_clr), .div_en(div_en), .div_result(div_result),
        .div_exception(div_exception), .div_rdy(div_rdy),
        .result(result), .result_exception(result_exception), .result_tag(result_tag),
        .result_valid(result_valid), .timeout(timeout)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Behavioural unit models: ready on the Nth enabled cycle after a clear.
    int mult_lat  = 5;
    int div_lat   = 34;
    bit div_stall = 1'b0;
    int mult_cnt  = 0;
    int div_cnt   = 0;

    always @(posedge clock) begin
        if (mult_clr)     mult_cnt <= 0;
        else if (mult_en) mult_cnt <= mult_cnt + 1;
        if (div_clr)      div_cnt  <= 0;
        else if (div_en)  div_cnt  <= div_cnt + 1;
    end

    assign mult_rdy       = mult_en && (mult_cnt == mult_lat - 1);
    assign div_rdy        = div_en && !div_stall && (div_cnt == div_lat - 1);
    assign mult_result    = unit_opA * unit_opB;
    assign mult_exception = 1'b0;
    assign div_exception  = (unit_opB == '0);
    always_comb begin
        div_result = '0;
        if (unit_opB != '0) div_result = DATA_W'($signed(unit_opA) / $signed(unit_opB));
    end

    // Completion monitor: records each result_valid cycle with its cycle number.
    typedef struct {
        logic [DATA_W-1:0] res;
        logic              exc;
        logic [TAG_W-1:0]  tag;
        logic              to;
        int                cyc;
    } done_t;
    done_t done_q[$];
    int div_en_cnt  = 0;
    int div_clr_cnt = 0;

    always @(posedge clock) begin
        if (result_valid) done_q.push_back('{result, result_exception, result_tag, timeout, cyc});
        if (div_en)  div_en_cnt  <= div_en_cnt + 1;
        if (div_clr) div_clr_cnt <= div_clr_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag);
        ctrl_MULT     = !is_div;
        ctrl_DIV      = is_div;
        data_operandA = a;
        data_operandB = b;
        op_tag        = tag;
    endtask

    task automatic idle_req();
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
    endtask

    task automatic wait_done(input int n);
        int k = 0;
        while (done_q.size() < n && k < 300) begin
            @(negedge clock);
            k++;
        end
        chk("wait_done.count", done_q.size(), n);
    endtask

    task automatic check_done(input string name, input logic [31:0] res, input logic exc,
                              input logic [4:0] tag, input logic to, input int t0, input int lat);
        done_t d;
        if (done_q.size() == 0) begin
            chk({name, ".present"}, 0, 1);
            return;
        end
        d = done_q.pop_front();
        chk({name, ".result"}, d.res, res);
        chk({name, ".exception"}, 32'(d.exc), 32'(exc));
        chk({name, ".tag"}, 32'(d.tag), 32'(tag));
        chk({name, ".timeout"}, 32'(d.to), 32'(to));
        chk({name, ".latency"}, d.cyc - t0, lat);
        $display("done %s: result=0x%0h exc=%0b tag=%0d timeout=%0b latency=%0d",
                 name, d.res, d.exc, d.tag, d.to, d.cyc - t0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int t0, snap, k;
        clear = 1'b1;
        idle_req();
        data_operandA = '0;
        data_operandB = '0;
        op_tag        = '0;

        // Reset state
        #12;
        chk("rst.busy", busy, 0);
        chk("rst.req_ready", req_ready, 1);
        chk("rst.mult_clr", mult_clr, 1);
        chk("rst.div_clr", div_clr, 1);
        chk("rst.result_valid", result_valid, 0);
        chk("rst.result", result, 0);
        chk("rst.unit_opA", unit_opA, 0);
        @(negedge clock);
        clear = 1'b0;
        @(negedge clock);

        // DIV 100/7 tag 3
        chk("div1.req_ready", req_ready, 1);
        snap = div_clr_cnt;
        issue(1, 100, 7, 3);
        t0 = cyc;
        @(negedge clock);
        idle_req();
        chk("div1.clr_T1", div_clr, 1);
        chk("div1.busy", busy, 1);
        chk("div1.unit_opA", unit_opA, 100);
        @(negedge clock);
        chk("div1.clr_T2", div_clr, 0);
        chk("div1.en_T2", div_en, 1);
        wait_done(1);
        check_done("div1", 14, 0, 3, 0, t0, 36);
        chk("div1.clr_cycles", div_clr_cnt - snap, 1);
        chk("div1.busy_after", busy, 0);
        chk("div1.result_hold", result, 14);

        // DIV -100/7 then MULT 6*7 queued while busy
        @(negedge clock);
        issue(1, 32'hFFFF_FF9C, 7, 1);
        t0 = cyc;
        @(negedge clock);
        idle_req();
        @(negedge clock);
        @(negedge clock);
        chk("pair.req_ready_once", req_ready, 1);
        issue(0, 6, 7, 2);
        @(negedge clock);
        idle_req();
        chk("pair.req_ready_full", req_ready, 0);
        wait_done(2);
        check_done("pair.div", 32'hFFFF_FFF2, 0, 1, 0, t0, 36);
        check_done("pair.mult", 42, 0, 2, 0, t0, 43);

        // Three ops back-to-back: third stalls until pending frees
        @(negedge clock);
        issue(0, 3, 4, 4);
        t0 = cyc;
        @(negedge clock);
        chk("three.req_ready_2nd", req_ready, 1);
        issue(0, 5, 6, 5);
        @(negedge clock);
        chk("three.req_ready_3rd", req_ready, 0);
        issue(1, 9, 3, 6);
        k = 0;
        while (!req_ready && k < 30) begin
            @(negedge clock);
            k++;
        end
        chk("three.accept_cycle", cyc - t0, 8);
        @(negedge clock);
        idle_req();
        wait_done(3);
        check_done("three.m1", 12, 0, 4, 0, t0, 7);
        check_done("three.m2", 30, 0, 5, 0, t0, 14);
        check_done("three.d3", 3, 0, 6, 0, t0, 50);

        // Divide by zero: resolved in CLR, divider never enabled
        @(negedge clock);
        snap = div_en_cnt;
        issue(1, 5, 0, 9);
        t0 = cyc;
        @(negedge clock);
        idle_req();
        wait_done(1);
        check_done("div0", 0, 1, 9, 0, t0, 2);
        chk("div0.en_cycles", div_en_cnt - snap, 0);

        // Watchdog expiry
        @(negedge clock);
        div_stall = 1'b1;
        issue(1, 8, 2, 7);
        t0 = cyc;
        @(negedge clock);
        idle_req();
        wait_done(1);
        check_done("wdog", 0, 1, 7, 1, t0, 42);
        div_stall = 1'b0;

        // Ready on the final watchdog cycle wins
        @(negedge clock);
        div_lat = 40;
        issue(1, 50, 5, 8);
        t0 = cyc;
        @(negedge clock);
        idle_req();
        wait_done(1);
        check_done("tie", 10, 0, 8, 0, t0, 42);
        div_lat = 34;

        // Illegal request
        @(negedge clock);
        ctrl_MULT = 1'b1;
        ctrl_DIV  = 1'b1;
        #1;
        chk("illegal.pulse", illegal_req, 1);
        chk("illegal.req_ready", req_ready, 1);
        @(negedge clock);
        idle_req();
        #1;
        chk("illegal.not_latched", busy, 0);
        chk("illegal.pulse_end", illegal_req, 0);

        // Clear asserted mid-RUN
        @(negedge clock);
        issue(1, 100, 7, 3);
        @(negedge clock);
        idle_req();
        repeat (5) @(negedge clock);
        chk("abort.busy_before", busy, 1);
        clear = 1'b1;
        #1;
        chk("abort.busy", busy, 0);
        chk("abort.req_ready", req_ready, 1);
        chk("abort.div_en", div_en, 0);
        chk("abort.div_clr", div_clr, 1);
        chk("abort.result", result, 0);
        chk("abort.result_valid", result_valid, 0);
        @(negedge clock);
        clear = 1'b0;
        repeat (45) @(negedge clock);
        chk("abort.no_result", done_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
